// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and width defaults for the
// shared-ALU controller.
package alu_pkg;

  localparam int unsigned DW_DEF  = 8;
  localparam int unsigned OW_DEF  = 9;
  localparam int unsigned OPW_DEF = 4;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: with both requesters valid the rr pointer picks,
// otherwise the single valid requester wins.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_rr,
  output logic [1:0] o_grant,
  output logic       o_idx
);

  always_comb begin
    o_idx   = i_rr;
    o_grant = '0;
    if (i_valid == 2'b01) begin
      o_idx = 1'b0;
    end else if (i_valid == 2'b10) begin
      o_idx = 1'b1;
    end
    if (|i_valid) begin
      o_grant = o_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: round-robin
// grant, registered operands, one-cycle execute and a held response.
module alu_share_ctrl #(
  parameter int unsigned DW     = 8,
  parameter int unsigned OW     = 9,
  parameter int unsigned OPW    = 4,
  parameter int unsigned OP_MAX = 5,
  parameter int unsigned CNTW   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*DW-1:0]  req_a,
  input  logic [2*DW-1:0]  req_b,
  input  logic [2*OPW-1:0] req_op,
  output logic [DW-1:0]    alu_a,
  output logic [DW-1:0]    alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [OW-1:0]    alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [OW-1:0]    rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNTW-1:0]  done_cnt
);
  import alu_pkg::*;

  state_t r_state, w_next;

  logic            r_rr;
  logic [1:0]      w_grant;
  logic            w_idx;
  logic            w_illegal;
  logic [DW-1:0]   w_sel_a, w_sel_b;
  logic [OPW-1:0]  w_sel_op;

  logic [DW-1:0]   r_alu_a, r_alu_b;
  logic [OPW-1:0]  r_alu_op;
  logic            r_rsp_valid, r_rsp_id, r_rsp_err;
  logic [OW-1:0]   r_rsp_data;
  logic [CNTW-1:0] r_done_cnt;

  rr_arb2 u_arb (
    .i_valid (req_valid),
    .i_rr    (r_rr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_sel_a   = w_idx ? req_a[DW +: DW]   : req_a[0 +: DW];
  assign w_sel_b   = w_idx ? req_b[DW +: DW]   : req_b[0 +: DW];
  assign w_sel_op  = w_idx ? req_op[OPW +: OPW] : req_op[0 +: OPW];
  assign w_illegal = (w_sel_op > OPW'(OP_MAX));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // In IDLE a non-zero grant is always a handshake since grants imply valid.
  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (|w_grant) begin
          w_next = w_illegal ? RESP : EXEC;
        end
      end
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr        <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_grant) begin
            r_alu_a  <= w_sel_a;
            r_alu_b  <= w_sel_b;
            r_alu_op <= w_sel_op;
            r_rsp_id <= w_idx;
            if (w_illegal) begin
              r_rsp_data  <= '0;
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
            end
          end
        end
        EXEC: begin
          r_rsp_data  <= alu_out;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rr        <= ~r_rsp_id;
            if (r_done_cnt != '1) begin
              r_done_cnt <= r_done_cnt + CNTW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != IDLE);
  assign done_cnt  = r_done_cnt;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU beside the DUT, a transaction-level
// reference model, directed scenarios and a randomized soak.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int unsigned OPMAX_L = 5;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, req_ready_2;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_op;
  logic [7:0]  alu_a, alu_b, alu_a_2, alu_b_2;
  logic [3:0]  alu_op, alu_op_2;
  logic [8:0]  alu_out, alu_out_2;
  logic        rsp_valid, rsp_valid_2, rsp_ready;
  logic        rsp_id, rsp_id_2, rsp_err, rsp_err_2;
  logic [8:0]  rsp_data, rsp_data_2;
  logic        busy, busy_2;
  logic [15:0] done_cnt;
  logic [1:0]  done_cnt_2;

  always #5 clk = ~clk;

  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    case (op)
      OP_ADD:  alu_fn = {1'b0, a} + {1'b0, b};
      OP_SUB:  alu_fn = {1'b0, a} - {1'b0, b};
      OP_AND:  alu_fn = {1'b0, a & b};
      OP_OR:   alu_fn = {1'b0, a | b};
      OP_XOR:  alu_fn = {1'b0, a ^ b};
      OP_SHL:  alu_fn = {a, 1'b0};
      default: alu_fn = {1'b1, a};
    endcase
  endfunction

  assign alu_out   = alu_fn(alu_a, alu_b, alu_op);
  assign alu_out_2 = alu_fn(alu_a_2, alu_b_2, alu_op_2);

  alu_share_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .done_cnt(done_cnt)
  );

  alu_share_ctrl #(.CNTW(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_2),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a_2), .alu_b(alu_b_2), .alu_op(alu_op_2), .alu_out(alu_out_2),
    .rsp_valid(rsp_valid_2), .rsp_ready(rsp_ready), .rsp_id(rsp_id_2),
    .rsp_data(rsp_data_2), .rsp_err(rsp_err_2), .busy(busy_2), .done_cnt(done_cnt_2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: one transaction outstanding from grant until its response
  // is accepted; the response appears (legal ? 2 : 1) cycles after the grant.
  txn_t        q0[$], q1[$];
  bit          m_out, m_rr, m_id, m_err;
  int          m_cd;
  logic [8:0]  m_data;
  logic [7:0]  m_a, m_b;
  logic [3:0]  m_op;
  int unsigned m_done, m_done2;

  bit          grant_log[$];
  logic [8:0]  data_log[$];
  bit          id_log[$], err_log[$];
  int          n_rsp = 0;

  task automatic step(input bit rdy, input bit rst);
    bit         v0, v1, eidx, ev, legal;
    logic [1:0] eg;
    txn_t       t;
    v0 = !rst && (q0.size() > 0);
    v1 = !rst && (q1.size() > 0);
    rst_n     = !rst;
    rsp_ready = rdy;
    req_valid = {v1, v0};
    req_a = '0; req_b = '0; req_op = '0;
    if (v0) begin t = q0[0]; req_a[7:0]  = t.a; req_b[7:0]  = t.b; req_op[3:0] = t.op; end
    if (v1) begin t = q1[0]; req_a[15:8] = t.a; req_b[15:8] = t.b; req_op[7:4] = t.op; end
    #1;
    eg = '0;
    eidx = 1'b0;
    if (!m_out && (v0 || v1)) begin
      eidx = (v0 && v1) ? m_rr : v1;
      eg   = eidx ? 2'b10 : 2'b01;
    end
    ev = m_out && (m_cd == 0);
    chk("req_ready", req_ready, eg);
    chk("rsp_valid", rsp_valid, ev);
    chk("busy", busy, m_out);
    chk("done_cnt", done_cnt, m_done);
    chk("done_cnt_sat", done_cnt_2, m_done2);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", alu_op, m_op);
    if (ev) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_err", rsp_err, m_err);
    end
    if (req_ready != 2'b00 && !rst) grant_log.push_back(req_ready[1]);
    if (rst) begin
      m_out = 0; m_cd = 0; m_rr = 0; m_done = 0; m_done2 = 0;
      m_a = '0; m_b = '0; m_op = '0;
    end else begin
      if (ev && rdy) begin
        m_out = 0;
        m_rr  = !m_id;
        if (m_done < 65535) m_done++;
        if (m_done2 < 3) m_done2++;
        data_log.push_back(rsp_data);
        id_log.push_back(rsp_id);
        err_log.push_back(rsp_err);
        n_rsp++;
      end else if (m_out && m_cd > 0) begin
        m_cd--;
      end
      if (eg != 2'b00) begin
        t      = eidx ? q1.pop_front() : q0.pop_front();
        legal  = (t.op <= 4'(OPMAX_L));
        m_out  = 1;
        m_id   = eidx;
        m_a    = t.a; m_b = t.b; m_op = t.op;
        m_cd   = legal ? 1 : 0;
        m_data = legal ? alu_fn(t.a, t.b, t.op) : 9'd0;
        m_err  = !legal;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    grant_log.delete(); data_log.delete(); id_log.delete(); err_log.delete();
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.a  = 8'($urandom);
    t.b  = 8'($urandom);
    t.op = ($urandom % 4 == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
    return t;
  endfunction

  initial begin
    int rsp_before;
    rst_n = 1'b0; rsp_ready = 1'b0; req_valid = '0;
    req_a = '0; req_b = '0; req_op = '0;
    @(posedge clk); #1;
    step(1, 1);

    // single legal add
    clear_logs();
    q0.push_back('{a: 8'd5, b: 8'd5, op: OP_ADD});
    repeat (5) step(1, 0);
    chk("t1_nrsp", data_log.size(), 1);
    if (data_log.size() == 1) begin
      chk("t1_data", data_log[0], 9'd10);
      chk("t1_id", id_log[0], 0);
      chk("t1_err", err_log[0], 0);
    end
    chk("t1_cnt", done_cnt, 1);

    // simultaneous requests from rr=0
    step(1, 1);
    clear_logs();
    q0.push_back('{a: 8'd5,   b: 8'd4, op: OP_ADD});
    q1.push_back('{a: 8'd255, b: 8'd1, op: OP_ADD});
    repeat (10) step(1, 0);
    chk("t2_ngrant", grant_log.size(), 2);
    chk("t2_nrsp", data_log.size(), 2);
    if (grant_log.size() == 2 && data_log.size() == 2) begin
      chk("t2_g0", grant_log[0], 0);
      chk("t2_g1", grant_log[1], 1);
      chk("t2_d0", data_log[0], 9'd9);
      chk("t2_d1", data_log[1], 9'd256);
      chk("t2_id1", id_log[1], 1);
    end

    // response backpressure with req1 waiting
    step(1, 1);
    clear_logs();
    q0.push_back('{a: 8'd7, b: 8'd3, op: OP_SUB});
    q1.push_back('{a: 8'd1, b: 8'd2, op: OP_OR});
    repeat (13) step(0, 0);
    chk("t3_wait_grants", grant_log.size(), 1);
    repeat (8) step(1, 0);
    chk("t3_nrsp", data_log.size(), 2);
    if (data_log.size() == 2) begin
      chk("t3_d0", data_log[0], 9'd4);
      chk("t3_d1", data_log[1], 9'd3);
    end

    // illegal opcode from requester 1
    step(1, 1);
    clear_logs();
    q1.push_back('{a: 8'd9, b: 8'd9, op: 4'b1010});
    repeat (4) step(1, 0);
    chk("t4_nrsp", data_log.size(), 1);
    if (data_log.size() == 1) begin
      chk("t4_err", err_log[0], 1);
      chk("t4_data", data_log[0], 9'd0);
      chk("t4_id", id_log[0], 1);
    end

    // reset while executing
    step(1, 1);
    q0.push_back('{a: 8'd1, b: 8'd2, op: OP_ADD});
    rsp_before = n_rsp;
    step(0, 0);
    step(0, 1);
    repeat (5) step(1, 0);
    chk("t5_no_rsp", n_rsp, rsp_before);

    // randomized soak
    step(1, 1);
    for (int unsigned c = 0; c < 3000; c++) begin
      if (q0.size() == 0 && $urandom % 3 == 0) q0.push_back(rand_txn());
      if (q1.size() == 0 && $urandom % 3 == 0) q1.push_back(rand_txn());
      step(($urandom % 3) != 0, 0);
    end
    repeat (12) step(1, 0);
    chk("drain_q", q0.size() + q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
